// File: rtl/midi_note_parser_if.sv
// Byte-stream input and note outputs of the MIDI note parser.
// The producer holds the master modport and the parser holds the slave modport.
interface midi_note_parser_if;
  logic [7:0] byteIn;
  logic       byteValid;
  logic [7:0] midiNoteNumber;
  logic [6:0] midiVelocity;
  logic       noteGate;
  logic       noteOnPulse;
  logic       noteOffPulse;

  modport master (
    output byteIn, byteValid,
    input  midiNoteNumber, midiVelocity, noteGate, noteOnPulse, noteOffPulse
  );

  modport slave (
    input  byteIn, byteValid,
    output midiNoteNumber, midiVelocity, noteGate, noteOnPulse, noteOffPulse
  );
endinterface

// File: rtl/midi_note_parser.sv
// Monophonic MIDI parser: tracks running status and decodes Note On/Off for one
// channel, or for every channel when OMNI is set. Last-note priority.
module midi_note_parser #(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  midi_note_parser_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DATA1, DATA2, SKIP} state_t;

  state_t     state_reg;
  logic [7:0] status_reg;
  logic [6:0] d1_reg;
  logic [6:0] note_reg;
  logic [6:0] vel_reg;
  logic       gate_reg;
  logic       on_reg;
  logic       off_reg;

  logic channel_ok;
  logic is_note_msg;

  assign channel_ok  = OMNI || (status_reg[3:0] == CHANNEL);
  assign is_note_msg = (status_reg[7:5] == 3'b100);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      status_reg <= 8'h00;
      d1_reg     <= 7'h00;
      note_reg   <= 7'h00;
      vel_reg    <= 7'h00;
      gate_reg   <= 1'b0;
      on_reg     <= 1'b0;
      off_reg    <= 1'b0;
    end else begin
      on_reg  <= 1'b0;
      off_reg <= 1'b0;
      if (bus.byteValid) begin
        // Real-time bytes (F8-FF) fall through every branch untouched.
        if (bus.byteIn[7:3] == 5'b11111) begin
        end else if (bus.byteIn[7:4] == 4'hF) begin
          status_reg <= 8'h00;
          state_reg  <= SKIP;
        end else if (bus.byteIn[7]) begin
          status_reg <= bus.byteIn;
          state_reg  <= DATA1;
        end else begin
          case (state_reg)
            DATA1: begin
              // Cn/Dn carry a single data byte: message done, stay in DATA1.
              if (status_reg[7:5] != 3'b110) begin
                d1_reg    <= bus.byteIn[6:0];
                state_reg <= DATA2;
              end
            end
            DATA2: begin
              state_reg <= DATA1;
              if (is_note_msg && channel_ok) begin
                if (status_reg[4] && (bus.byteIn[6:0] != 7'h00)) begin
                  note_reg <= d1_reg;
                  vel_reg  <= bus.byteIn[6:0];
                  gate_reg <= 1'b1;
                  on_reg   <= 1'b1;
                end else if (gate_reg && (d1_reg == note_reg)) begin
                  gate_reg <= 1'b0;
                  off_reg  <= 1'b1;
                end
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign bus.midiNoteNumber = {1'b0, note_reg};
  assign bus.midiVelocity   = vel_reg;
  assign bus.noteGate       = gate_reg;
  assign bus.noteOnPulse    = on_reg;
  assign bus.noteOffPulse   = off_reg;

endmodule

// File: tb/tb_midi_note_parser.sv
// Bench for midi_note_parser: directed scenarios plus random byte streams, with
// two instances (channel 0 filtered, and OMNI) checked against a message-level model.
module tb_midi_note_parser;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  midi_note_parser_if bus0 ();
  midi_note_parser_if bus1 ();

  midi_note_parser #(.CHANNEL(4'd0), .OMNI(1'b0)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
  midi_note_parser #(.CHANNEL(4'd3), .OMNI(1'b1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: running status plus a queue of the data bytes collected so far.
  int        m_chan [2] = '{0, 3};
  bit        m_omni [2] = '{1'b0, 1'b1};
  int        m_rs   [2];
  logic [7:0] m_q   [2][$];
  logic [7:0] m_note[2];
  logic [6:0] m_vel [2];
  logic       m_gate[2];
  logic       m_on  [2];
  logic       m_off [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rs[k] = -1;
      m_q[k].delete();
      m_note[k] = 8'h00; m_vel[k] = 7'h00;
      m_gate[k] = 1'b0;  m_on[k] = 1'b0; m_off[k] = 1'b0;
    end
  endfunction

  function automatic void model_byte(input int k, input logic valid, input logic [7:0] b);
    int hi;
    int need;
    m_on[k]  = 1'b0;
    m_off[k] = 1'b0;
    if (!valid || b >= 8'hF8) return;
    if (b >= 8'hF0) begin m_rs[k] = -1; m_q[k].delete(); return; end
    if (b >= 8'h80) begin m_rs[k] = int'(b); m_q[k].delete(); return; end
    if (m_rs[k] < 0) return;
    m_q[k].push_back(b);
    hi   = m_rs[k] / 16;
    need = (hi == 12 || hi == 13) ? 1 : 2;
    if (m_q[k].size() < need) return;
    if ((hi == 8 || hi == 9) && (m_omni[k] || (m_rs[k] % 16) == m_chan[k])) begin
      if (hi == 9 && m_q[k][1] != 8'h00) begin
        m_note[k] = m_q[k][0];
        m_vel[k]  = m_q[k][1][6:0];
        m_gate[k] = 1'b1;
        m_on[k]   = 1'b1;
      end else if (m_gate[k] && m_q[k][0] == m_note[k]) begin
        m_gate[k] = 1'b0;
        m_off[k]  = 1'b1;
      end
    end
    m_q[k].delete();
  endfunction

  task automatic compare_all();
    check("d0_note", bus0.midiNoteNumber, m_note[0]);
    check("d0_vel",  bus0.midiVelocity,   m_vel[0]);
    check("d0_gate", bus0.noteGate,       m_gate[0]);
    check("d0_on",   bus0.noteOnPulse,    m_on[0]);
    check("d0_off",  bus0.noteOffPulse,   m_off[0]);
    check("d1_note", bus1.midiNoteNumber, m_note[1]);
    check("d1_vel",  bus1.midiVelocity,   m_vel[1]);
    check("d1_gate", bus1.noteGate,       m_gate[1]);
    check("d1_on",   bus1.noteOnPulse,    m_on[1]);
    check("d1_off",  bus1.noteOffPulse,   m_off[1]);
    check("d0_pulse_excl", bus0.noteOnPulse & bus0.noteOffPulse, 1'b0);
  endtask

  task automatic step(input logic valid, input logic [7:0] b);
    @(negedge clk);
    bus0.byteValid = valid; bus0.byteIn = b;
    bus1.byteValid = valid; bus1.byteIn = b;
    @(posedge clk);
    #1;
    model_byte(0, valid, b);
    model_byte(1, valid, b);
    $display("byte valid=%0d 0x%02h -> d0 note=%02h vel=%02h gate=%0d on=%0d off=%0d | d1 gate=%0d",
             valid, b, bus0.midiNoteNumber, bus0.midiVelocity, bus0.noteGate,
             bus0.noteOnPulse, bus0.noteOffPulse, bus1.noteGate);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    bus0.byteValid = 1'b0; bus1.byteValid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    $display("reset");
    compare_all();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic send(input logic [7:0] seq[$]);
    foreach (seq[i]) step(1'b1, seq[i]);
  endtask

  function automatic logic [7:0] gen_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 45) begin
      if ($urandom_range(0, 2) == 0) return 8'h00;
      if ($urandom_range(0, 1) == 0) return 8'h3C + 8'($urandom_range(0, 3));
      return 8'($urandom_range(0, 127));
    end
    if (r < 70) return {4'($urandom_range(8, 9)), 4'($urandom_range(0, 4))};
    if (r < 78) return 8'($urandom_range(8'hA0, 8'hEF));
    if (r < 88) return 8'($urandom_range(8'hF8, 8'hFF));
    return 8'($urandom_range(8'hF0, 8'hF7));
  endfunction

  initial begin
    bus0.byteValid = 1'b0; bus0.byteIn = 8'h00;
    bus1.byteValid = 1'b0; bus1.byteIn = 8'h00;
    model_reset();
    do_reset();

    // Scenario 1
    send('{8'h90, 8'h3C, 8'h64});
    check("s1_note", bus0.midiNoteNumber, 8'h3C);
    check("s1_vel",  bus0.midiVelocity,   7'h64);
    check("s1_on",   bus0.noteOnPulse,    1'b1);
    step(1'b0, 8'h00);
    check("s1_on_once", bus0.noteOnPulse, 1'b0);
    check("s1_gate_hold", bus0.noteGate, 1'b1);

    // Scenario 2: running status, non-current off, current off
    send('{8'h3E, 8'h40});
    check("s2_note", bus0.midiNoteNumber, 8'h3E);
    send('{8'h3C, 8'h00});
    check("s2_gate_kept", bus0.noteGate, 1'b1);
    send('{8'h3E, 8'h00});
    check("s2_off", bus0.noteOffPulse, 1'b1);
    check("s2_note_held", bus0.midiNoteNumber, 8'h3E);

    // Scenario 3: real-time interleave
    do_reset();
    send('{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64});
    check("s3_note", bus0.midiNoteNumber, 8'h3C);
    check("s3_gate", bus0.noteGate, 1'b1);

    // Scenario 4: channel filter vs OMNI
    do_reset();
    send('{8'h91, 8'h3C, 8'h64});
    check("s4_filtered", bus0.noteGate, 1'b0);
    check("s4_omni", bus1.midiNoteNumber, 8'h3C);

    // Scenario 5: abort, system messages, program change
    do_reset();
    send('{8'h90, 8'h3C, 8'h80, 8'h3C, 8'h00});
    send('{8'hF0, 8'h3C, 8'h64, 8'hF7, 8'h3C, 8'h64});
    check("s5_no_note", bus0.noteGate, 1'b0);
    send('{8'hC0, 8'h05, 8'h90, 8'h45, 8'h7F});
    check("s5_note", bus0.midiNoteNumber, 8'h45);

    // Scenario 6: reset mid-message
    do_reset();
    send('{8'h90, 8'h3C});
    do_reset();
    send('{8'h64});
    check("s6_no_note", bus0.noteGate, 1'b0);

    // Random streams
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      else if ($urandom_range(0, 4) == 0) step(1'b0, gen_byte());
      else step(1'b1, gen_byte());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/midi_note_parser.md
Name: midi_note_parser

Overview:
- Monophonic MIDI byte-stream parser that sits directly upstream of the MIDI-note-to-sample-ticks lookup.
- Consumes received MIDI bytes from the UART receiver.
- Tracks running status and decodes Note On and Note Off messages for one channel.
- Drives the current note number, velocity and a gate to the note lookup and envelope stages.

Parameters:
- CHANNEL, 0, MIDI channel to accept (0-15, matched against the status low nibble).
- OMNI, 0, when 1, accept note messages on all channels and ignore CHANNEL.

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous, active-low reset
- byteIn  input  8  received MIDI byte
- byteValid  input  1  byteIn is valid this cycle; one byte is accepted per cycle when high
- midiNoteNumber  output  8  current note number, bit 7 always 0; feeds the ticks lookup
- midiVelocity  output  7  velocity of the current note
- noteGate  output  1  high while the current note is held
- noteOnPulse  output  1  one-cycle strobe on each accepted Note On
- noteOffPulse  output  1  one-cycle strobe when the gate falls

Behaviour:
- Reset and timing
  - Reset is synchronous and active-low; the only clock is clk.
  - While resetn=0 at a clk edge: midiNoteNumber=0, midiVelocity=0, noteGate=0, noteOnPulse=0, noteOffPulse=0, running status cleared, FSM=IDLE.
  - Reset asserted mid-message discards the partial message.
  - A byte is sampled at a rising edge of clk when byteValid=1.
  - All outputs are registered. The result of a completing byte is visible the cycle after it is sampled (latency 1).
  - Pulses are high for exactly one cycle. Nothing changes when byteValid=0.
- Byte classes
  - Real-time, F8-FF: ignored completely. No change to state, running status or the data-byte count, including between data bytes.
  - System common/exclusive, F0-F7: clears running status; FSM goes to SKIP. In SKIP, all data bytes are discarded until the next status byte 80-EF.
  - Channel voice status, 80-EF: stored as running status; FSM goes to DATA1. This aborts any partial message and discards its first data byte.
  - Data byte, 00-7F: handled per FSM state.
- FSM states
  - IDLE: no running status; data bytes discarded.
  - DATA1, on a data byte:
    - If running status is 8n/9n, An, Bn or En: latch the byte as d1 and go to DATA2.
    - If running status is Cn or Dn: the message is complete and ignored; stay in DATA1.
  - DATA2, on a data byte: the message is complete; act on it (below), then return to DATA1 with running status retained.
  - SKIP: as described under byte classes.
- Actions on a completed message
  - Only 8n and 9n messages act, and only when n==CHANNEL or OMNI=1. All others are consumed silently.
  - 9n with velocity>0:
    - midiNoteNumber={0,d1}, midiVelocity=velocity, noteGate=1, noteOnPulse=1.
    - This applies even if the gate was already high (retrigger, last-note priority).
  - 8n with any velocity, or 9n with velocity 0: treated as Note Off.
    - If noteGate=1 and d1==midiNoteNumber[6:0]: noteGate=0, noteOffPulse=1.
    - Otherwise ignored.
    - midiNoteNumber and midiVelocity hold their values after Note Off, so the release tail keeps its pitch.
- Boundary cases
  - noteOnPulse and noteOffPulse are never high in the same cycle.
  - A Note Off for a non-current note never lowers the gate.

Test Plan:
1. CHANNEL=0: bytes 90 3C 64 → cycle after 64: midiNoteNumber=0x3C, midiVelocity=0x64, noteGate=1, noteOnPulse high for 1 cycle.
2. Running status: 90 3C 64 then 3E 40 → second noteOnPulse, midiNoteNumber=0x3E, midiVelocity=0x40, gate stays 1. Then 3C 00 → no change (non-current note). Then 3E 00 → noteGate=0, noteOffPulse for 1 cycle, midiNoteNumber stays 0x3E.
3. Real-time interleave: 90 F8 3C FE 64 → same outputs as scenario 1.
4. Channel filter: CHANNEL=0, bytes 91 3C 64 → no output change. Same sequence with OMNI=1 → note 0x3C on.
5. Abort and system messages:
   - 90 3C 80 3C 00 → only the Note Off is processed; the gate stays 0 and no noteOnPulse occurs.
   - F0 3C 64 F7 3C 64 → no output change.
   - C0 05 then 90 45 7F → program change consumed; note 0x45 on.
6. Reset mid-message: 90 3C, then resetn=0 for 1 cycle, then 64 → no note (running status cleared). All outputs read 0 after reset.
